// File: rtl/pipe_stage_buf_pkg.sv
// pipe_pkg: shared payload widths, field offsets and NOP payload for pipeline stage buffers
package pipe_pkg;
  localparam int MAX_W = 128;
  localparam int ALUSEL_W = 8;
  localparam int OPND_W = 32;
  localparam int WD_W = 5;
  localparam int INST_W = 32;
  localparam int BR_W = 18;
  localparam int IF_ID_PC_LSB = 0;
  localparam int IF_ID_INST_LSB = 32;
  localparam int IF_ID_W = 64;
  localparam int ID_EX_ALUSEL_LSB = 0;
  localparam int ID_EX_OP1_LSB = ID_EX_ALUSEL_LSB + ALUSEL_W;
  localparam int ID_EX_OP2_LSB = ID_EX_OP1_LSB + OPND_W;
  localparam int ID_EX_WD_LSB = ID_EX_OP2_LSB + OPND_W;
  localparam int ID_EX_WREG_LSB = ID_EX_WD_LSB + WD_W;
  localparam int ID_EX_INST_LSB = ID_EX_WREG_LSB + 1;
  localparam int ID_EX_BR_LSB = ID_EX_INST_LSB + INST_W;
  localparam int ID_EX_W = ID_EX_BR_LSB + BR_W;
  localparam int EX_MEM_WD_LSB = 0;
  localparam int EX_MEM_WREG_LSB = EX_MEM_WD_LSB + WD_W;
  localparam int EX_MEM_WDATA_LSB = EX_MEM_WREG_LSB + 1;
  localparam int EX_MEM_ALUSEL_LSB = EX_MEM_WDATA_LSB + OPND_W;
  localparam int EX_MEM_ADDR_LSB = EX_MEM_ALUSEL_LSB + ALUSEL_W;
  localparam int EX_MEM_OP2_LSB = EX_MEM_ADDR_LSB + OPND_W;
  localparam int EX_MEM_W = EX_MEM_OP2_LSB + OPND_W;
  localparam int MEM_WB_W = WD_W + 1 + OPND_W;
  typedef enum logic [1:0] {STG_IF_ID, STG_ID_EX, STG_EX_MEM, STG_MEM_WB} stage_e;
  function automatic logic [MAX_W-1:0] nop_payload();
    return '0;
  endfunction
endpackage

// File: rtl/pipe_stage_buf_if.sv
// pipe_stage_buf_if: valid/ready/data handshake channel between pipeline stages
interface pipe_stage_buf_if #(parameter int DATA_W = 128);
  logic valid;
  logic ready;
  logic [DATA_W-1:0] data;
  modport master (output valid, output data, input ready);
  modport slave (input valid, input data, output ready);
endinterface

// File: rtl/pipe_stage_buf_mem.sv
// pipe_buf_mem: DEPTH x DATA_W entry array, one write port, async read port
module pipe_buf_mem #(
  parameter int DATA_W = 128,
  parameter int DEPTH = 2,
  parameter int AW = 1
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end
  assign rdata = mem[raddr];
endmodule

// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: elastic DEPTH-entry in-order pipeline stage register with flush and bubble zeroing
module pipe_stage_buf
  import pipe_pkg::*;
#(
  parameter int DATA_W = 128,
  parameter int DEPTH = 2,
  parameter int ZERO_ON_BUBBLE = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  pipe_stage_buf_if.slave              up,
  pipe_stage_buf_if.master             dn,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [DATA_W-1:0] rd_data;
  logic push, pop;
  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return p == PW'(DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  assign up.ready = count < CW'(DEPTH);
  assign dn.valid = count != '0;
  assign push = up.valid & up.ready & ~flush;
  assign pop = dn.valid & dn.ready & ~flush;
  assign dn.data = dn.valid || ZERO_ON_BUBBLE == 0 ? rd_data : DATA_W'(nop_payload());
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      count <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= inc(wr_ptr);
      if (pop) rd_ptr <= inc(rd_ptr);
      count <= count + CW'(push) - CW'(pop);
    end
  end
  pipe_buf_mem #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(PW)) u_mem (
    .clk(clk), .we(push), .waddr(wr_ptr), .wdata(up.data), .raddr(rd_ptr), .rdata(rd_data)
  );
  assert property (@(posedge clk) disable iff (rst) count <= CW'(DEPTH));
  assert property (@(posedge clk) disable iff (rst) dn.valid && !dn.ready && !flush |=> $stable(dn.data));
  assert property (@(posedge clk) DEPTH >= 1 && DEPTH <= 4);
endmodule

// File: tb/tb_pipe_stage_buf.sv
// tb_pipe_stage_buf: three buffer depths checked each cycle against a queue model plus literal expectations
module tb_pipe_stage_buf;
  localparam int W = 8;
  logic clk = 0, rst = 1, flush = 0, run = 0;
  logic iv [3];
  logic [W-1:0] id [3];
  logic ordy [3];
  wire ird [3];
  wire ov [3];
  wire [W-1:0] od [3];
  wire [31:0] cnt [3];
  int checks = 0, passes = 0, cyc = 0;
  always #5 clk = ~clk;
  always @(negedge clk) cyc++;
  task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s inst%0d t=%0t got %0h want %0h", nm, i, $time, act, exp);
  endtask
  task automatic step();
    @(negedge clk);
  endtask
  for (genvar i = 0; i < 3; i++) begin : u
    localparam int D = i == 0 ? 2 : i == 1 ? 3 : 1;
    pipe_stage_buf_if #(.DATA_W(W)) up ();
    pipe_stage_buf_if #(.DATA_W(W)) dn ();
    logic [$clog2(D+1)-1:0] count;
    logic [W-1:0] q [$];
    logic [W-1:0] olog [$];
    int ot [$];
    int dmax = 0;
    assign up.valid = iv[i];
    assign up.data = id[i];
    assign dn.ready = ordy[i];
    assign ird[i] = up.ready;
    assign ov[i] = dn.valid;
    assign od[i] = dn.data;
    assign cnt[i] = 32'(count);
    pipe_stage_buf #(.DATA_W(W), .DEPTH(D), .ZERO_ON_BUBBLE(1)) dut (
      .clk(clk), .rst(rst), .flush(flush), .up(up), .dn(dn), .count(count)
    );
    always @(posedge clk) begin
      bit a;
      if (rst || flush) q.delete();
      else begin
        a = iv[i] && q.size() < D;
        if (q.size() != 0 && ordy[i]) begin
          olog.push_back(q[0]);
          ot.push_back(cyc);
          void'(q.pop_front());
        end
        if (a) q.push_back(id[i]);
      end
    end
    always @(negedge clk) if (run) begin
      chk("out_valid", i, 32'(dn.valid), 32'(q.size() != 0));
      chk("in_ready", i, 32'(up.ready), 32'(q.size() < D));
      chk("count", i, 32'(count), 32'(q.size()));
      chk("out_data", i, 32'(dn.data), q.size() != 0 ? 32'(q[0]) : 32'h0);
      if (int'(count) > dmax) dmax = int'(count);
    end
  end
  task automatic offer(input int i, input logic [W-1:0] v);
    bit a;
    id[i] = v;
    iv[i] = 1;
    for (int k = 0; k < 50; k++) begin
      a = ird[i] && !flush;
      step();
      if (a) begin
        iv[i] = 0;
        return;
      end
    end
    chk("offer_timeout", i, 0, 1);
    iv[i] = 0;
  endtask
  initial begin
    logic [W-1:0] wd [10];
    logic [W-1:0] v;
    bit a;
    bit acc [3];
    int n, t;
    for (int i = 0; i < 3; i++) begin
      iv[i] = 1;
      id[i] = 8'hA5;
      ordy[i] = 1;
      acc[i] = 0;
    end
    rst = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 0;
    for (int i = 0; i < 3; i++) iv[i] = 0;
    run = 1;
    chk("rst_count", 0, cnt[0], 0);
    chk("rst_ready", 0, 32'(ird[0]), 1);
    chk("rst_valid", 0, 32'(ov[0]), 0);
    chk("rst_data", 0, 32'(od[0]), 0);
    repeat (3) step();
    for (int i = 0; i < 3; i++) chk("rst_nothing_out", i, u[0].olog.size() + u[1].olog.size() + u[2].olog.size(), 0);
    u[0].dmax = 0;
    for (int k = 1; k <= 8; k++) offer(0, W'(k));
    repeat (3) step();
    chk("stream_len", 0, u[0].olog.size(), 8);
    for (int k = 0; k < 8 && k < u[0].olog.size(); k++) begin
      chk("stream_data", 0, 32'(u[0].olog[k]), k + 1);
      chk("stream_gap", 0, u[0].ot[k] - u[0].ot[0], k);
    end
    chk("stream_max", 0, u[0].dmax, 1);
    u[0].olog.delete();
    ordy[0] = 0;
    offer(0, 8'h11);
    offer(0, 8'h22);
    id[0] = 8'h33;
    iv[0] = 1;
    repeat (2) step();
    chk("full_count", 0, cnt[0], 2);
    chk("full_ready", 0, 32'(ird[0]), 0);
    ordy[0] = 1;
    offer(0, 8'h33);
    repeat (4) step();
    chk("bp_len", 0, u[0].olog.size(), 3);
    if (u[0].olog.size() == 3) begin
      chk("bp_0", 0, 32'(u[0].olog[0]), 32'h11);
      chk("bp_1", 0, 32'(u[0].olog[1]), 32'h22);
      chk("bp_2", 0, 32'(u[0].olog[2]), 32'h33);
    end
    u[0].olog.delete();
    ordy[0] = 0;
    offer(0, 8'h44);
    offer(0, 8'h55);
    chk("pre_flush_count", 0, cnt[0], 2);
    flush = 1;
    iv[0] = 1;
    id[0] = 8'h66;
    step();
    flush = 0;
    iv[0] = 0;
    chk("flush_count", 0, cnt[0], 0);
    chk("flush_valid", 0, 32'(ov[0]), 0);
    chk("flush_data", 0, 32'(od[0]), 0);
    ordy[0] = 1;
    repeat (4) step();
    chk("flush_nothing_out", 0, u[0].olog.size(), 0);
    for (int k = 0; k < 10; k++) wd[k] = W'($urandom);
    u[1].olog.delete();
    u[1].dmax = 0;
    n = 0;
    t = 0;
    while (n < 10 && t < 200) begin
      ordy[1] = (t % 2 == 0);
      id[1] = wd[n];
      iv[1] = 1;
      a = ird[1];
      step();
      if (a) n++;
      t++;
    end
    iv[1] = 0;
    ordy[1] = 1;
    repeat (5) step();
    chk("wrap_len", 1, u[1].olog.size(), 10);
    for (int k = 0; k < 10 && k < u[1].olog.size(); k++) chk("wrap_data", 1, 32'(u[1].olog[k]), 32'(wd[k]));
    chk("wrap_max_le3", 1, 32'(u[1].dmax <= 3), 1);
    u[2].olog.delete();
    ordy[2] = 1;
    v = 0;
    for (int k = 0; k < 12; k++) begin
      id[2] = v;
      iv[2] = 1;
      chk("d1_ready_alt", 2, 32'(ird[2]), 32'(k % 2 == 0));
      a = ird[2];
      step();
      if (a) v++;
    end
    iv[2] = 0;
    repeat (3) step();
    chk("d1_len", 2, u[2].olog.size(), 6);
    for (int k = 0; k < 6 && k < u[2].olog.size(); k++) chk("d1_data", 2, 32'(u[2].olog[k]), k);
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 3; i++) begin
        if (!iv[i] || acc[i]) begin
          iv[i] = $urandom_range(0, 3) != 0;
          id[i] = W'($urandom);
        end
        ordy[i] = $urandom_range(0, 3) != 0;
      end
      flush = $urandom_range(0, 99) == 0;
      rst = $urandom_range(0, 199) == 0;
      for (int i = 0; i < 3; i++) acc[i] = iv[i] && ird[i] && !flush && !rst;
      step();
    end
    rst = 0;
    flush = 0;
    for (int i = 0; i < 3; i++) iv[i] = 0;
    repeat (5) step();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/pipe_stage_buf.md
Name: pipe_stage_buf

Overview:
- Parametrised elastic pipeline-stage register for inter-stage boundaries (IF/ID, ID/EX, EX/MEM, ...).
- Generalises the fixed single-entry, stall/flush-controlled stage register. Adds:
  - a valid/ready handshake on both sides;
  - configurable payload width;
  - DEPTH-entry in-order buffering, so upstream is not stalled by a one-cycle downstream hiccup.
- Bubbles are explicit (out_valid=0). With ZERO_ON_BUBBLE=1 the payload is also zeroed, so the downstream stage sees a NOP exactly as it does today.

Parameters:
- DATA_W, 128: payload width in bits (concatenated alusel/operands/wd/wreg/inst/br fields).
- DEPTH, 2: number of buffer entries, 1..4.
- ZERO_ON_BUBBLE, 1: 1 = out_data forced to all-zero whenever out_valid=0; 0 = out_data undefined when invalid.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous reset, active-high.
- flush  in  1  branch-mispredict/interception kill; discards all held and incoming entries.
- in_valid  in  1  upstream has a payload this cycle.
- in_ready  out  1  buffer can accept; registered, equals (count < DEPTH).
- in_data  in  DATA_W  upstream payload.
- out_valid  out  1  head entry present; registered, equals (count != 0).
- out_ready  in  1  downstream accepts the head this cycle (0 = downstream stall).
- out_data  out  DATA_W  head payload.
- count  out  $clog2(DEPTH+1)  current occupancy.

Behaviour:
- push = in_valid & in_ready & ~flush.
- pop = out_valid & out_ready & ~flush.
- Priority per edge: rst > flush > normal push/pop.
- rst: count=0, rd/wr pointers=0, out_valid=0, in_ready=1, out_data=0. Entry storage need not be cleared.
- Reset applied mid-operation discards everything on that edge. in_valid in the reset cycle is ignored.
- flush: same effect as rst on the next edge (count=0, pointers=0, out_valid=0, out_data=0). A push offered in the flush cycle is dropped and must not appear later.
- Normal operation:
  - Storage is a circular buffer of DEPTH entries with wr_ptr/rd_ptr.
  - Pointers wrap modulo DEPTH; DEPTH need not be a power of two, so wrap is explicit compare-to-(DEPTH-1).
  - push only: write at wr_ptr, wr_ptr++, count++.
  - pop only: rd_ptr++, count--.
  - push & pop in the same cycle: both pointers advance, count unchanged.
- Latency: a payload pushed into an empty buffer at edge t is visible on out_data with out_valid=1 after edge t (one cycle). No combinational path from in_* to out_*.
- No combinational path from out_ready to in_ready. in_ready depends only on registered count.
  - Consequence: with DEPTH=1, a full buffer refuses a push even while popping, giving 50% throughput.
  - DEPTH>=2 sustains 1 transfer/cycle.
- Full (count==DEPTH): in_ready=0. Upstream must hold in_valid/in_data stable until accepted.
- Empty (count==0): out_valid=0. out_ready is ignored. out_data=0 if ZERO_ON_BUBBLE.
- Order: strictly FIFO; no reordering and no duplication.
- Assertions (sim only):
  - count never exceeds DEPTH;
  - out_data stable while out_valid & ~out_ready & ~flush;
  - DEPTH within 1..4.

Decomposition:
- Shared package pipe_pkg holds:
  - per-stage payload-width constants (ID_EX_W, EX_MEM_W, ...);
  - field offset constants, so stages pack and unpack in_data/out_data consistently;
  - a function returning an all-zero NOP payload.
- One natural sub-module: pipe_buf_mem, the DEPTH x DATA_W register array with a write port and an asynchronous read-at-rd_ptr port.
- Pointer/count control stays in pipe_stage_buf.

Test Plan:
- Reset/idle: assert rst 2 cycles with in_valid=1, in_data=0xA5 -> after release out_valid=0, out_data=0, count=0, in_ready=1; nothing emerges.
- Streaming, DEPTH=2: push 0x01..0x08 on consecutive cycles, out_ready=1 -> out_data 0x01..0x08 one cycle behind, no gaps, count stays at most 1.
- Backpressure/full: DEPTH=2, out_ready=0, offer 0x11,0x22,0x33 -> count=2, in_ready=0 while 0x33 is held. Raise out_ready -> output 0x11,0x22,0x33 in order.
- Flush: fill with 0x44,0x55, then flush=1 with in_valid=1, in_data=0x66 -> next cycle count=0, out_valid=0, out_data=0. 0x66 never appears.
- Wrap, DEPTH=3: 10 pushes with out_ready toggling 1,0,1,0... -> pointers wrap repeatedly, output sequence equals input sequence, count never exceeds 3.
- DEPTH=1 throughput: continuous in_valid, out_ready=1 -> exactly one transfer every 2 cycles, in_ready alternates 1,0.
